// File: rtl/gd_report_pkg.sv
// Shared definitions for the gradient-descent result reporter: FSM encoding, frame constants, baud math.
// Frame length depends on GD_TX_CHECKSUM_EN (defined: 10 bytes incl. XOR checksum, undefined: 9 bytes).
// No logic; constants and a constant function only.
package gd_report_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_RUN   = 3'd2,
    ST_LATCH = 3'd3,
    ST_SEND  = 3'd4
  } state_t;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

`ifdef GD_TX_CHECKSUM_EN
  localparam int FRAME_LEN = 10;
`else
  localparam int FRAME_LEN = 9;
`endif

  // Integer-truncated number of clock cycles per UART bit.
  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/gd_uart_byte_tx.sv
// 8N1 byte serializer: start bit, 8 data bits LSB-first, stop bit, each CLKS_PER_BIT cycles.
// Latency: tx drops to the start bit on the edge that accepts a byte.
// Backpressure: ready is high when idle or in the last cycle of the stop bit, allowing back-to-back bytes.
module gd_uart_byte_tx
  import gd_report_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       ready,
  output logic       tx,
  output logic       byte_done
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  logic             active;
  logic [CNT_W-1:0] baud_cnt;
  logic [3:0]       bit_idx;
  logic [7:0]       shreg;
  logic             bit_end;

  assign bit_end   = active && (baud_cnt == CNT_W'(CLKS_PER_BIT - 1));
  assign byte_done = bit_end && (bit_idx == 4'd9);
  assign ready     = !active || byte_done;

  // Baud counter, bit index and line driver; a new byte preempts the final stop-bit cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      active   <= 1'b0;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      tx       <= 1'b1;
    end else if (valid && ready) begin
      active   <= 1'b1;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= data;
      tx       <= 1'b0;
    end else if (bit_end) begin
      baud_cnt <= '0;
      if (bit_idx == 4'd9) begin
        active  <= 1'b0;
        bit_idx <= '0;
        tx      <= 1'b1;
      end else begin
        bit_idx <= bit_idx + 4'd1;
        tx      <= (bit_idx == 4'd8) ? 1'b1 : shreg[bit_idx[2:0]];
      end
    end else if (active) begin
      baud_cnt <= baud_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/gd_result_uart_tx.sv
// Runs one timer measurement per trigger and reports SYNC + time_elapsed + flops_count (+ XOR checksum with GD_TX_CHECKSUM_EN) over UART 8N1.
// Latency: trigger to first start bit is 3 cycles plus the RUN wait for timer_done.
// Backpressure: trigger is ignored while busy; nothing is queued.
module gd_result_uart_tx
  import gd_report_pkg::*;
#(
  parameter int         CLK_HZ       = 100_000_000,
  parameter int         BAUD         = 115200,
  parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEFAULT,
  parameter int         DONE_TIMEOUT = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        trigger,
  output logic        timer_clear,
  output logic        timer_start,
  input  logic        timer_done,
  input  logic [31:0] time_elapsed,
  input  logic [31:0] flops_count,
  output logic        tx,
  output logic        busy,
  output logic        frame_sent,
  output logic        timeout
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD);
  localparam int WAIT_W       = $clog2(DONE_TIMEOUT + 1);

  state_t            state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt;
  logic [3:0]        byte_idx;
  logic [31:0]       te_q, fc_q;
  logic [63:0]       payload;
  logic [7:0]        byte_sel;
  logic              last_byte, run_expired;
  logic              ser_valid, ser_ready, ser_done;
  logic [7:0]        ser_data;

  assign payload     = {fc_q, te_q};
  assign last_byte   = (byte_idx == 4'(FRAME_LEN - 1));
  assign run_expired = (wait_cnt == WAIT_W'(DONE_TIMEOUT - 1));

  // byte_idx names the byte currently on the line, so the next byte is payload[byte_idx].
`ifdef GD_TX_CHECKSUM_EN
  logic [7:0] checksum;

  // XOR of the eight payload bytes; the sync byte is not covered.
  always_comb begin
    checksum = '0;
    for (int i = 0; i < 8; i++) checksum = checksum ^ payload[8*i +: 8];
  end

  assign byte_sel = (byte_idx == 4'd8) ? checksum : payload[{byte_idx[2:0], 3'b000} +: 8];
`else
  assign byte_sel = payload[{byte_idx[2:0], 3'b000} +: 8];
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (trigger) state_nxt = ST_CLEAR;
      ST_CLEAR: state_nxt = ST_RUN;
      ST_RUN: begin
        if (timer_done)       state_nxt = ST_LATCH;
        else if (run_expired) state_nxt = ST_IDLE;
      end
      ST_LATCH: state_nxt = ST_SEND;
      ST_SEND:  if (ser_done && last_byte) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Outputs decoded from state; the sync byte is handed over in LATCH so tx starts on entry to SEND.
  always_comb begin
    busy        = (state != ST_IDLE);
    timer_clear = (state == ST_CLEAR);
    timer_start = (state == ST_RUN);
    ser_valid   = 1'b0;
    ser_data    = SYNC_BYTE;
    if (state == ST_SEND) begin
      ser_valid = ser_done && !last_byte;
      ser_data  = byte_sel;
    end else if (state == ST_LATCH) begin
      ser_valid = 1'b1;
    end
  end

  // Wait counter, shadow capture, byte sequencing and the status flags.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wait_cnt   <= '0;
      byte_idx   <= '0;
      te_q       <= '0;
      fc_q       <= '0;
      timeout    <= 1'b0;
      frame_sent <= 1'b0;
    end else begin
      frame_sent <= 1'b0;
      case (state)
        ST_IDLE:  if (trigger) timeout <= 1'b0;
        ST_CLEAR: wait_cnt <= '0;
        ST_RUN: begin
          if (!timer_done) begin
            if (run_expired) timeout <= 1'b1;
            else             wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        ST_LATCH: begin
          te_q     <= time_elapsed;
          fc_q     <= flops_count;
          byte_idx <= '0;
        end
        ST_SEND: begin
          if (ser_done) begin
            if (last_byte) frame_sent <= 1'b1;
            else           byte_idx   <= byte_idx + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  gd_uart_byte_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte_tx (
    .clk      (clk),
    .rst      (rst),
    .data     (ser_data),
    .valid    (ser_valid),
    .ready    (ser_ready),
    .tx       (tx),
    .byte_done(ser_done)
  );

endmodule

// File: tb/tb_gd_result_uart_tx.sv
// Directed bench for gd_result_uart_tx with a fast baud setting (8 clocks per bit).
// Frame length follows GD_TX_CHECKSUM_EN like the design.
// Outputs are sampled and inputs driven on the falling clock edge.
module tb_gd_result_uart_tx;

  localparam int CPB = 8;
`ifdef GD_TX_CHECKSUM_EN
  localparam int NB = 10;
`else
  localparam int NB = 9;
`endif

  typedef struct packed {
    logic [31:0] te;
    logic [31:0] fc;
    logic [7:0]  dly;
    logic [79:0] exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        trigger = 1'b0;
  logic        timer_done = 1'b0;
  logic [31:0] time_elapsed = '0;
  logic [31:0] flops_count = '0;
  logic        timer_clear, timer_start, tx, busy, frame_sent, timeout;

  int errors = 0;
  int checks = 0;
  vec_t vecs [4];

  always #5 clk = ~clk;

  gd_result_uart_tx #(
    .CLK_HZ(1_000_000),
    .BAUD(125_000),
    .SYNC_BYTE(8'hA5),
    .DONE_TIMEOUT(4096)
  ) dut (
    .clk(clk),
    .rst(rst),
    .trigger(trigger),
    .timer_clear(timer_clear),
    .timer_start(timer_start),
    .timer_done(timer_done),
    .time_elapsed(time_elapsed),
    .flops_count(flops_count),
    .tx(tx),
    .busy(busy),
    .frame_sent(frame_sent),
    .timeout(timeout)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_start(output bit seen);
    int guard;
    guard = 0;
    while (tx !== 1'b0 && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    seen = (tx === 1'b0);
    chk("start_seen", {31'd0, tx}, 32'd0);
  endtask

  // Decodes one frame bit by bit at fixed offsets from the first start bit, then times frame_sent.
  task automatic capture(output logic [79:0] got, output int fs_off);
    bit seen;
    int cur;
    int tgt;
    got = '0;
    fs_off = -1;
    wait_start(seen);
    if (!seen) return;
    cur = 0;
    for (int b = 0; b < NB; b++) begin
      for (int k = 0; k < 10; k++) begin
        tgt = b*10*CPB + k*CPB + CPB/2;
        while (cur < tgt) begin
          @(negedge clk);
          cur++;
        end
        if (k == 0)      chk($sformatf("start_bit%0d", b), {31'd0, tx}, 32'd0);
        else if (k == 9) chk($sformatf("stop_bit%0d", b), {31'd0, tx}, 32'd1);
        else             got[72 - 8*b + (k-1)] = tx;
      end
    end
    while (frame_sent !== 1'b1 && cur < NB*10*CPB + 50) begin
      @(negedge clk);
      cur++;
    end
    if (frame_sent === 1'b1) fs_off = cur;
  endtask

  // mode 0: plain run, 4: extra trigger pulse mid-frame, 6: timer inputs change mid-frame.
  task automatic run_vec(input vec_t v, input int mode);
    logic [79:0] got;
    int fs_off;
    int busy_hits;
    timer_done = 1'b0;
    time_elapsed = v.te;
    flops_count = v.fc;
    @(negedge clk);
    trigger = 1'b1;
    @(negedge clk);
    trigger = 1'b0;
    chk("clear_pulse", {31'd0, timer_clear}, 32'd1);
    chk("timeout_cleared", {31'd0, timeout}, 32'd0);
    chk("busy_after_trigger", {31'd0, busy}, 32'd1);
    @(negedge clk);
    chk("clear_one_cycle", {31'd0, timer_clear}, 32'd0);
    chk("start_in_run", {31'd0, timer_start}, 32'd1);
    repeat (int'(v.dly)) @(negedge clk);
    timer_done = 1'b1;
    fork
      capture(got, fs_off);
      begin
        if (mode == 6) begin
          repeat (20) @(negedge clk);
          time_elapsed = 32'hFFFF_FFFF;
          flops_count = 32'hFFFF_FFFF;
        end else if (mode == 4) begin
          repeat (300) @(negedge clk);
          trigger = 1'b1;
          @(negedge clk);
          trigger = 1'b0;
        end
      end
    join
    for (int b = 0; b < NB; b++)
      chk($sformatf("byte%0d", b), {24'd0, got[79 - 8*b -: 8]}, {24'd0, v.exp[79 - 8*b -: 8]});
    chk("frame_duration", fs_off, NB*10*CPB);
    chk("idle_at_frame_sent", {31'd0, busy}, 32'd0);
    @(negedge clk);
    chk("frame_sent_one_cycle", {31'd0, frame_sent}, 32'd0);
    timer_done = 1'b0;
    busy_hits = 0;
    repeat (40) begin
      @(negedge clk);
      if (busy || !tx) busy_hits++;
    end
    chk("no_extra_run", busy_hits, 0);
  endtask

  initial begin
    int cnt;
    int hits;
    bit seen;

    vecs[0] = '{te: 32'h0000_01F4, fc: 32'h0000_09C4, dly: 8'd0,   exp: 80'hA5_F4_01_00_00_C4_09_00_00_38};
    vecs[1] = '{te: 32'h1234_5678, fc: 32'hDEAD_BEEF, dly: 8'd5,   exp: 80'hA5_78_56_34_12_EF_BE_AD_DE_2A};
    vecs[2] = '{te: 32'h0000_0000, fc: 32'h0000_0000, dly: 8'd37,  exp: 80'hA5_00_00_00_00_00_00_00_00_00};
    vecs[3] = '{te: 32'hFFFF_FFFF, fc: 32'h8000_0001, dly: 8'd200, exp: 80'hA5_FF_FF_FF_FF_01_00_00_80_81};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_tx", {31'd0, tx}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_frame_sent", {31'd0, frame_sent}, 32'd0);
    chk("rst_timeout", {31'd0, timeout}, 32'd0);
    chk("rst_timer_clear", {31'd0, timer_clear}, 32'd0);
    chk("rst_timer_start", {31'd0, timer_start}, 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Timeout: timer_done never arrives
    timer_done = 1'b0;
    trigger = 1'b1;
    @(negedge clk);
    trigger = 1'b0;
    cnt = 0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (timer_start) cnt++;
      else if (cnt > 0) break;
    end
    chk("run_cycles_before_timeout", cnt, 4096);
    chk("timeout_set", {31'd0, timeout}, 32'd1);
    chk("timeout_busy", {31'd0, busy}, 32'd0);
    chk("timeout_tx", {31'd0, tx}, 32'd1);
    hits = 0;
    repeat (30) begin
      @(negedge clk);
      if (frame_sent || !tx) hits++;
    end
    chk("timeout_no_frame", hits, 0);
    chk("timeout_sticky", {31'd0, timeout}, 32'd1);

    // Table of full frames
    for (int i = 0; i < 4; i++) run_vec(vecs[i], 0);

    // Trigger pulsed mid-frame is ignored
    run_vec(vecs[1], 4);

    // Timer inputs change after capture
    run_vec(vecs[0], 6);

    // Reset during byte 4, bit 3 (time_elapsed[31:24]=0x12, data bit 2 = 0)
    time_elapsed = vecs[1].te;
    flops_count = vecs[1].fc;
    @(negedge clk);
    trigger = 1'b1;
    @(negedge clk);
    trigger = 1'b0;
    repeat (3) @(negedge clk);
    timer_done = 1'b1;
    wait_start(seen);
    repeat (4*10*CPB + 3*CPB + CPB/2) @(negedge clk);
    chk("pre_reset_tx_low", {31'd0, tx}, 32'd0);
    chk("pre_reset_busy", {31'd0, busy}, 32'd1);
    rst = 1'b0;
    @(negedge clk);
    chk("midframe_reset_tx", {31'd0, tx}, 32'd1);
    chk("midframe_reset_busy", {31'd0, busy}, 32'd0);
    rst = 1'b1;
    timer_done = 1'b0;
    hits = 0;
    repeat (200) begin
      @(negedge clk);
      if (!tx || busy || frame_sent) hits++;
    end
    chk("no_resume_after_reset", hits, 0);
    run_vec(vecs[0], 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
